// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: prefix codes, key map,
// joystick bit positions and the receiver frame state encoding.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_REL   = 8'hF0;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ALT   = 8'h11;
    localparam logic [7:0] SC_F2    = 8'h06;

    localparam int JOY_FIRE    = 0;
    localparam int JOY_START1  = 1;
    localparam int JOY_START2  = 2;
    localparam int JOY_COIN    = 3;
    localparam int JOY_UP      = 4;
    localparam int JOY_DOWN    = 5;
    localparam int JOY_LEFT    = 6;
    localparam int JOY_RIGHT   = 7;
    localparam int JOY_BOMB    = 8;
    localparam int JOY_SERVICE = 9;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, frame FSM and
// mid-frame timeout. Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           filt, filt_prev;
    logic [FCW-1:0] fcnt;
    logic           fall;
    rx_state_t      state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           par;
    logic [14:0]    tmo;
    logic           par_ok;

    always_ff @(posedge clk) begin
        clk_s1 <= ps2_clk;
        clk_s2 <= clk_s1;
        dat_s1 <= ps2_data;
        dat_s2 <= dat_s1;
    end

    // Filtered clock only follows the line after FILTER_LEN agreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt      <= 1'b1;
            filt_prev <= 1'b1;
            fcnt      <= '0;
        end else begin
            filt_prev <= filt;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
                filt <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt;

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^{shreg, par};
`else
    logic unused_par;
    assign par_ok     = 1'b1;
    assign unused_par = par;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tmo   <= '0;
        end else if (state == IDLE) begin
            tmo <= '0;
            if (fall && !dat_s2) begin
                state   <= DATA;
                bit_cnt <= '0;
            end
        end else if (fall) begin
            tmo <= '0;
            if (state == DATA) begin
                shreg   <= {dat_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == 3'd7) state <= PARITY;
            end else if (state == PARITY) begin
                par   <= dat_s2;
                state <= STOP;
            end else begin
                state <= IDLE;
            end
        end else if (tmo == 15'(TIMEOUT_CYC - 1)) begin
            state <= IDLE;
            tmo   <= '0;
        end else if (tmo != 15'h7FFF) begin
            tmo <= tmo + 1'b1;
        end
    end

    // Acceptance is flagged on the stop-bit fall itself so the decoder's
    // registered outputs land one clock later.
    assign rx_valid = (state == STOP) && fall && dat_s2 && par_ok;
    assign rx_byte  = shreg;

endmodule

// File: rtl/ps2_kbd_joy.sv
// PS/2 keyboard to level-held joystick vector with E0/F0 prefix tracking.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity frame rejection in ps2_rx.
module ps2_kbd_joy
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic [9:0] joystick,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       ext, rel;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_kbd_clk),
        .ps2_data (ps2_kbd_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

    // Keypad keys share codes with the E0 arrows, so arrows ignore ext.
    function automatic logic [9:0] key_mask(input logic [7:0] code, input logic is_ext);
        logic [9:0] m;
        m = '0;
        case (code)
            SC_SPACE: m[JOY_FIRE]    = 1'b1;
            SC_1:     m[JOY_START1]  = 1'b1;
            SC_2:     m[JOY_START2]  = 1'b1;
            SC_5:     m[JOY_COIN]    = 1'b1;
            SC_UP:    m[JOY_UP]      = 1'b1;
            SC_DOWN:  m[JOY_DOWN]    = 1'b1;
            SC_LEFT:  m[JOY_LEFT]    = 1'b1;
            SC_RIGHT: m[JOY_RIGHT]   = 1'b1;
            SC_ALT:   m[JOY_BOMB]    = 1'b1;
            SC_F2:    m[JOY_SERVICE] = ~is_ext;
            default:  m = '0;
        endcase
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            joystick    <= '0;
            key_strobe  <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            ext         <= 1'b0;
            rel         <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (rx_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_REL) begin
                    rel <= 1'b1;
                end else begin
                    key_strobe  <= 1'b1;
                    key_code    <= rx_byte;
                    key_ext     <= ext;
                    key_release <= rel;
                    ext         <= 1'b0;
                    rel         <= 1'b0;
                    if (rel) joystick <= joystick & ~key_mask(rx_byte, ext);
                    else     joystick <= joystick |  key_mask(rx_byte, ext);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_joy.sv
// Directed bench for ps2_kbd_joy: bit-banged PS/2 frames with hand-computed results.
module tb_ps2_kbd_joy;

    localparam int FLT = 8;
    localparam int TMO = 25000;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_kbd_clk;
    logic       ps2_kbd_data;
    logic [9:0] joystick;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;

    int n_checks = 0;
    int n_err    = 0;
    int n_strobe = 0;
    int lat      = 0;

    ps2_kbd_joy #(
        .FILTER_LEN  (FLT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data),
        .joystick     (joystick),
        .key_strobe   (key_strobe),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_release  (key_release)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_strobe) n_strobe++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic glitch, input logic meas);
        ps2_kbd_data = b;
        if (glitch) begin
            wait_n(5);
            ps2_kbd_clk = 1'b0;
            wait_n(1);
            ps2_kbd_clk = 1'b1;
            wait_n(4);
        end else begin
            wait_n(10);
        end
        ps2_kbd_clk = 1'b0;
        if (meas) begin
            lat = 0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (key_strobe && lat == 0) lat = i;
            end
        end else begin
            wait_n(20);
        end
        ps2_kbd_clk = 1'b1;
        wait_n(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input int nbits = 11,
                              input logic bad_par = 1'b0, input logic glitch = 1'b0,
                              input logic meas = 1'b0);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], glitch, meas && (i == 10));
        ps2_kbd_data = 1'b1;
        wait_n(20);
    endtask

    initial begin
        reset        = 1'b1;
        ps2_kbd_clk  = 1'b1;
        ps2_kbd_data = 1'b1;
        wait_n(5);
        reset = 1'b0;
        wait_n(2);
        chk("rst_joy",  32'(joystick), 32'h000);
        chk("rst_stb",  32'(key_strobe), 32'h0);
        chk("rst_code", 32'(key_code), 32'h00);
        chk("rst_ext",  32'(key_ext), 32'h0);
        chk("rst_rel",  32'(key_release), 32'h0);

        send_frame(8'h29);
        chk("space_joy",  32'(joystick), 32'h001);
        chk("space_code", 32'(key_code), 32'h29);
        chk("space_rel",  32'(key_release), 32'h0);
        chk("space_nstb", 32'(n_strobe), 32'd1);
        chk("stb_pulse",  32'(key_strobe), 32'h0);

        send_frame(8'hF0);
        send_frame(8'h29);
        chk("spcrel_joy",  32'(joystick), 32'h000);
        chk("spcrel_rel",  32'(key_release), 32'h1);
        chk("spcrel_code", 32'(key_code), 32'h29);
        chk("spcrel_nstb", 32'(n_strobe), 32'd2);

        send_frame(8'hE0);
        send_frame(8'h75);
        chk("up_joy",  32'(joystick), 32'h010);
        chk("up_ext",  32'(key_ext), 32'h1);
        chk("up_code", 32'(key_code), 32'h75);
        chk("up_rel",  32'(key_release), 32'h0);
        send_frame(8'h11);
        chk("alt_joy",  32'(joystick), 32'h110);
        chk("alt_ext",  32'(key_ext), 32'h0);
        chk("alt_nstb", 32'(n_strobe), 32'd4);

        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        chk("uprel_joy",  32'(joystick), 32'h100);
        chk("uprel_ext",  32'(key_ext), 32'h1);
        chk("uprel_rel",  32'(key_release), 32'h1);
        chk("uprel_nstb", 32'(n_strobe), 32'd5);

        send_frame(8'hE0);
        send_frame(8'h06);
        chk("f2ext_joy",  32'(joystick), 32'h100);
        chk("f2ext_ext",  32'(key_ext), 32'h1);
        chk("f2ext_code", 32'(key_code), 32'h06);

        send_frame(8'hE1);
        chk("e1_joy",  32'(joystick), 32'h100);
        chk("e1_code", 32'(key_code), 32'hE1);
        chk("e1_nstb", 32'(n_strobe), 32'd7);

        send_frame(8'h16, 5);
        wait_n(TMO + 10);
        chk("abort_nstb", 32'(n_strobe), 32'd7);
        send_frame(8'h16);
        chk("tmo_joy",  32'(joystick), 32'h102);
        chk("tmo_code", 32'(key_code), 32'h16);
        chk("tmo_nstb", 32'(n_strobe), 32'd8);

        send_frame(8'h1E, 11, 1'b0, 1'b1);
        chk("glitch_joy",  32'(joystick), 32'h106);
        chk("glitch_code", 32'(key_code), 32'h1E);
        chk("glitch_nstb", 32'(n_strobe), 32'd9);

        send_frame(8'h2E, 11, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        chk("badpar_joy",  32'(joystick), 32'h106);
        chk("badpar_nstb", 32'(n_strobe), 32'd9);
`else
        chk("badpar_joy",  32'(joystick), 32'h10E);
        chk("badpar_nstb", 32'(n_strobe), 32'd10);
`endif

        reset = 1'b1;
        wait_n(1);
        reset = 1'b0;
        wait_n(2);
        send_frame(8'h1E);
        chk("pre_rst_joy", 32'(joystick), 32'h004);
        send_frame(8'h29, 4);
        reset = 1'b1;
        wait_n(1);
        reset = 1'b0;
        chk("midrst_joy",  32'(joystick), 32'h000);
        chk("midrst_code", 32'(key_code), 32'h00);
        chk("midrst_ext",  32'(key_ext), 32'h0);
        chk("midrst_rel",  32'(key_release), 32'h0);
        chk("midrst_stb",  32'(key_strobe), 32'h0);
        send_frame(8'h06, 11, 1'b0, 1'b0, 1'b1);
        chk("svc_joy",  32'(joystick), 32'h200);
        chk("svc_code", 32'(key_code), 32'h06);
        chk("svc_ext",  32'(key_ext), 32'h0);
        chk("svc_lat",  32'(lat), 32'(FLT + 3));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
